// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - opcodes, default latencies and decode helpers for the MDU controller
package mdu_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MTHI  = 4'd5;
    localparam logic [3:0] MDU_MTLO  = 4'd6;
    localparam logic [3:0] MDU_MFHI  = 4'd7;
    localparam logic [3:0] MDU_MFLO  = 4'd8;

    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES  = 10;

    function automatic logic is_md_start(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic is_md_mult(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

endpackage

// File: rtl/mdu_compute.sv
// rtl/mdu_compute.sv - combinational multiply/divide result generator for HI/LO
module mdu_compute
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic [31:0] hi_next,
    output logic [31:0] lo_next,
    output logic        div_zero
);

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic               sdiv;
    logic [31:0]        num;
    logic [31:0]        den;
    logic [31:0]        den_safe;
    logic [31:0]        uq;
    logic [31:0]        ur;
    logic [31:0]        quot;
    logic [31:0]        rem;

    assign prod_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
    assign prod_u = {32'd0, rs} * {32'd0, rt};

    // Signed divide runs on magnitudes; INT_MIN/-1 then falls out as 0x80000000 rem 0.
    assign sdiv     = (op == MDU_DIV);
    assign num      = (sdiv && rs[31]) ? (32'd0 - rs) : rs;
    assign den      = (sdiv && rt[31]) ? (32'd0 - rt) : rt;
    assign div_zero = (rt == 32'd0) && ((op == MDU_DIV) || (op == MDU_DIVU));
    assign den_safe = (rt == 32'd0) ? 32'd1 : den;
    assign uq       = num / den_safe;
    assign ur       = num % den_safe;
    assign quot     = (sdiv && (rs[31] ^ rt[31])) ? (32'd0 - uq) : uq;
    assign rem      = (sdiv && rs[31]) ? (32'd0 - ur) : ur;

    always_comb begin
        hi_next = 32'd0;
        lo_next = 32'd0;
        case (op)
            MDU_MULT:  {hi_next, lo_next} = prod_s;
            MDU_MULTU: {hi_next, lo_next} = prod_u;
            MDU_DIV, MDU_DIVU: begin
                hi_next = rem;
                lo_next = quot;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - MDU sequencer: busy counter, HI/LO ownership, D-stage stall and read mux
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  e_op,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    input  logic        d_is_md,
    output logic        busy,
    output logic        stall_d,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_rdata
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] LAST      = CW'(1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [31:0]   pend_hi_q, pend_hi_d;
    logic [31:0]   pend_lo_q, pend_lo_d;
    logic          busy_q, busy_d;

    logic [31:0]   hi_next;
    logic [31:0]   lo_next;
    logic          div_zero;

    mdu_compute u_compute (
        .op       (e_op),
        .rs       (e_rs),
        .rt       (e_rt),
        .hi_next  (hi_next),
        .lo_next  (lo_next),
        .div_zero (div_zero)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        case (state_q)
            S_IDLE: begin
                if (is_md_start(e_op)) begin
                    // A divide by zero re-commits the current HI/LO so completion is uniform.
                    pend_hi_d = div_zero ? hi_q : hi_next;
                    pend_lo_d = div_zero ? lo_q : lo_next;
                    count_d   = is_md_mult(e_op) ? MULT_LOAD : DIV_LOAD;
                    state_d   = S_RUN;
                end else if (e_op == MDU_MTHI) begin
                    hi_d = e_rs;
                end else if (e_op == MDU_MTLO) begin
                    lo_d = e_rs;
                end
            end
            S_RUN: begin
                count_d = count_q - LAST;
                if (count_q == LAST) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            busy_q    <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign stall_d = d_is_md & (busy_q | is_md_start(e_op));

    always_comb begin
        md_rdata = 32'd0;
        if (e_op == MDU_MFHI) begin
            md_rdata = hi_q;
        end else if (e_op == MDU_MFLO) begin
            md_rdata = lo_q;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - directed and random checks of mdu_ctrl against an arithmetic HI/LO model
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  e_op;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic        d_is_md;
    logic        busy;
    logic        stall_d;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_rdata;

    int checks   = 0;
    int failures = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .e_op     (e_op),
        .e_rs     (e_rs),
        .e_rt     (e_rt),
        .d_is_md  (d_is_md),
        .busy     (busy),
        .stall_d  (stall_d),
        .hi       (hi),
        .lo       (lo),
        .md_rdata (md_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural result of a mult/div, straight from the arithmetic definitions.
    task automatic model_md(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
        longint      ps;
        logic [63:0] pu;
        int          a;
        int          b;
        case (op)
            MDU_MULT: begin
                ps = longint'($signed(rs)) * longint'($signed(rt));
                {m_hi, m_lo} = ps;
            end
            MDU_MULTU: begin
                pu = {32'd0, rs} * {32'd0, rt};
                {m_hi, m_lo} = pu;
            end
            MDU_DIV: begin
                if (rt != 0) begin
                    if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) begin
                        m_lo = 32'h8000_0000;
                        m_hi = 32'd0;
                    end else begin
                        a = rs;
                        b = rt;
                        m_lo = a / b;
                        m_hi = a % b;
                    end
                end
            end
            MDU_DIVU: begin
                if (rt != 0) begin
                    m_lo = rs / rt;
                    m_hi = rs % rt;
                end
            end
            default: ;
        endcase
    endtask

    task automatic run_md(input string tag, input logic [3:0] op, input logic [31:0] rs,
                          input logic [31:0] rt, input logic dmd);
        int n;
        int exp_n;
        exp_n = (op == MDU_MULT || op == MDU_MULTU) ? 5 : 10;
        chk({tag, "_idle_before_issue"}, busy, 1'b0);
        e_op = op; e_rs = rs; e_rt = rt; d_is_md = dmd;
        #1;
        chk({tag, "_stall_issue"}, stall_d, dmd);
        model_md(op, rs, rt);
        tick();
        e_op = MDU_NONE; e_rs = 32'd0; e_rt = 32'd0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            chk({tag, "_stall_busy"}, stall_d, dmd);
            n++;
            tick();
        end
        chk({tag, "_busy_cycles"}, n, exp_n);
        chk({tag, "_stall_after"}, stall_d, 1'b0);
        chk({tag, "_hi"}, hi, m_hi);
        chk({tag, "_lo"}, lo, m_lo);
        d_is_md = 1'b0;
    endtask

    task automatic run_mt(input string tag, input logic [3:0] op, input logic [31:0] v);
        e_op = op; e_rs = v; e_rt = $urandom;
        if (op == MDU_MTHI) m_hi = v; else m_lo = v;
        tick();
        e_op = MDU_NONE; e_rs = 32'd0; e_rt = 32'd0;
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_hi"}, hi, m_hi);
        chk({tag, "_lo"}, lo, m_lo);
    endtask

    task automatic check_mf(input string tag);
        e_op = MDU_MFHI;
        #1;
        chk({tag, "_mfhi"}, md_rdata, m_hi);
        e_op = MDU_MFLO;
        #1;
        chk({tag, "_mflo"}, md_rdata, m_lo);
        e_op = MDU_NONE;
        #1;
        chk({tag, "_none_rdata"}, md_rdata, 32'd0);
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        int          n;

        reset = 1'b1; e_op = MDU_NONE; e_rs = 32'd0; e_rt = 32'd0; d_is_md = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_stall", stall_d, 1'b0);
        chk("rst_rdata", md_rdata, 32'd0);
        reset = 1'b0;
        tick();

        run_md("mult_neg", MDU_MULT, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
        chk("mult_neg_hi_const", hi, 32'hFFFF_FFFF);
        chk("mult_neg_lo_const", lo, 32'hFFFF_FFFE);
        run_md("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
        chk("multu_hi_const", hi, 32'h0000_0001);
        run_md("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
        chk("div_neg_lo_const", lo, 32'hFFFF_FFFD);
        chk("div_neg_hi_const", hi, 32'hFFFF_FFFF);
        run_md("divu", MDU_DIVU, 32'd7, 32'd2, 1'b0);
        chk("divu_lo_const", lo, 32'd3);
        run_md("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("div_ovf_lo_const", lo, 32'h8000_0000);
        chk("div_ovf_hi_const", hi, 32'd0);

        run_mt("mthi", MDU_MTHI, 32'h11);
        run_mt("mtlo", MDU_MTLO, 32'h22);
        run_md("div_zero", MDU_DIV, 32'd5, 32'd0, 1'b1);
        chk("div_zero_hi_const", hi, 32'h11);
        chk("div_zero_lo_const", lo, 32'h22);

        run_mt("mtlo_abcd", MDU_MTLO, 32'hABCD);
        e_op = MDU_MFLO;
        #1;
        chk("mflo_next_cycle", md_rdata, 32'hABCD);
        e_op = MDU_NONE;
        #1;
        chk("none_rdata", md_rdata, 32'd0);

        for (int i = 0; i < 30; i++) begin
            op = 4'($urandom_range(1, 6));
            rs = $urandom;
            rt = $urandom;
            case ($urandom_range(0, 9))
                0: rt = 32'd0;
                1: begin rs = 32'h8000_0000; rt = 32'hFFFF_FFFF; end
                2: rt = 32'($urandom_range(1, 9));
                default: ;
            endcase
            if (is_md_start(op)) begin
                run_md("rnd_md", op, rs, rt, 1'($urandom_range(0, 1)));
            end else begin
                run_mt("rnd_mt", op, rs);
            end
            check_mf("rnd_read");
        end

        run_mt("pre_rst_hi", MDU_MTHI, 32'h1234_5678);
        e_op = MDU_DIVU; e_rs = 32'd100; e_rt = 32'd7;
        tick();
        e_op = MDU_NONE;
        tick();
        tick();
        chk("rst_mid_busy_before", busy, 1'b1);
        reset = 1'b1;
        e_op = MDU_MTLO; e_rs = 32'hDEAD_BEEF;
        tick();
        reset = 1'b0;
        e_op = MDU_NONE; e_rs = 32'd0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);
        n = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) n++;
        end
        chk("rst_mid_no_stale_write", n, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
